// File: rtl/mem_bus_delay_pkg.sv
// Shared types, defaults and delay clamping for the memory request delay line.
package mem_bus_delay_pkg;

  localparam int DEF_ADDR_W        = 8;
  localparam int DEF_DATA_W        = 32;
  localparam int DEF_MAX_DELAY     = 8;
  localparam int DEF_DEFAULT_DELAY = 4;

  localparam int CTRL_W = 3;

  typedef struct packed {
    logic ce;
    logic rw;
    logic clr;
  } ctrl_t;

  // A delay of zero would bypass the line entirely, so it is raised to one.
  function automatic int unsigned clamp_dly(input int unsigned v, input int unsigned max_d);
    if (v == 0) return 1;
    if (v > max_d) return max_d;
    return v;
  endfunction

endpackage

// File: rtl/mem_bus_delay_line_if.sv
// Request/response bundle between the request stage and the RAM model.
interface mem_bus_delay_line_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DLY_W  = 4
);
  logic [ADDR_W-1:0] mar_i;
  logic [DATA_W-1:0] data_i;
  logic              ce_i;
  logic              rw_i;
  logic              clr_i;
  logic              in_valid_i;
  logic              stall_i;
  logic              flush_i;
  logic              dly_load_i;
  logic [DLY_W-1:0]  dly_i;
  logic [ADDR_W-1:0] mar_o;
  logic [DATA_W-1:0] data_o;
  logic              ce_o;
  logic              rw_o;
  logic              clr_o;
  logic              out_valid_o;
  logic              busy_o;
  logic [DLY_W-1:0]  dly_o;
  logic              dly_err_o;

  modport master (
    output mar_i, data_i, ce_i, rw_i, clr_i, in_valid_i, stall_i, flush_i, dly_load_i, dly_i,
    input  mar_o, data_o, ce_o, rw_o, clr_o, out_valid_o, busy_o, dly_o, dly_err_o
  );

  modport slave (
    input  mar_i, data_i, ce_i, rw_i, clr_i, in_valid_i, stall_i, flush_i, dly_load_i, dly_i,
    output mar_o, data_o, ce_o, rw_o, clr_o, out_valid_o, busy_o, dly_o, dly_err_o
  );
endinterface

// File: rtl/mem_bus_delay_stage.sv
// One delay-line position: payload plus valid, held on stall, emptied on flush.
module mem_bus_delay_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [W-1:0] payload_i,
  output logic         valid_o,
  output logic [W-1:0] payload_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (!stall_i) begin
      valid_d   = valid_i;
      payload_d = payload_i;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
endmodule

// File: rtl/mem_bus_delay_line.sv
// Runtime-programmable delay line for memory requests with stall, flush and bubble-safe outputs.
module mem_bus_delay_line
  import mem_bus_delay_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_DELAY     = DEF_MAX_DELAY,
  parameter int DEFAULT_DELAY = DEF_DEFAULT_DELAY,
  parameter int DLY_W         = $clog2(MAX_DELAY + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_bus_delay_line_if.slave  bus
);
  localparam int PW = CTRL_W + ADDR_W + DATA_W;

  logic [MAX_DELAY-1:0] stg_vld_in, stg_vld;
  logic [PW-1:0]        stg_pay_in [MAX_DELAY];
  logic [PW-1:0]        stg_pay    [MAX_DELAY];

  logic                 tap_vld;
  logic [PW-1:0]        tap_pay;
  logic                 busy;
  logic                 load_ok, load_rej;

  logic                 out_vld_q, out_vld_d;
  logic [ADDR_W-1:0]    mar_q, mar_d;
  logic [DATA_W-1:0]    data_q, data_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic                 err_q, err_d;

  // Positions at or beyond the active delay never receive a valid entry, so
  // busy reflects only requests that are still on their way to the output.
  always_comb begin
    stg_vld_in[0] = bus.in_valid_i;
    stg_pay_in[0] = {ctrl_t'({bus.ce_i, bus.rw_i, bus.clr_i}), bus.mar_i, bus.data_i};
    for (int i = 1; i < MAX_DELAY; i++) begin
      stg_vld_in[i] = stg_vld[i-1] && (DLY_W'(i) < dly_q);
      stg_pay_in[i] = stg_pay[i-1];
    end
  end

  for (genvar g = 0; g < MAX_DELAY; g++) begin : g_stage
    mem_bus_delay_stage #(.W(PW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall_i   (bus.stall_i),
      .flush_i   (bus.flush_i),
      .valid_i   (stg_vld_in[g]),
      .payload_i (stg_pay_in[g]),
      .valid_o   (stg_vld[g]),
      .payload_o (stg_pay[g])
    );
  end

  always_comb begin
    tap_vld = 1'b0;
    tap_pay = '0;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (dly_q == DLY_W'(i + 1)) begin
        tap_vld = stg_vld[i];
        tap_pay = stg_pay[i];
      end
    end
  end

  assign busy     = |stg_vld;
  assign load_ok  = bus.dly_load_i && (bus.flush_i || (!bus.stall_i && !busy && !out_vld_q));
  assign load_rej = bus.dly_load_i && !bus.flush_i && !bus.stall_i && (busy || out_vld_q);

  always_comb begin
    out_vld_d = out_vld_q;
    mar_d     = mar_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    dly_d     = load_ok ? DLY_W'(clamp_dly(32'(bus.dly_i), MAX_DELAY)) : dly_q;
    err_d     = load_rej;
    if (bus.flush_i) begin
      out_vld_d = 1'b0;
      ctrl_d    = '0;
    end else if (!bus.stall_i) begin
      out_vld_d = tap_vld;
      if (tap_vld) begin
        ctrl_d = ctrl_t'(tap_pay[PW-1 -: CTRL_W]);
        mar_d  = tap_pay[DATA_W +: ADDR_W];
        data_d = tap_pay[DATA_W-1:0];
      end else begin
        ctrl_d = '0;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      mar_q     <= '0;
      data_q    <= '0;
      ctrl_q    <= '0;
      dly_q     <= DLY_W'(DEFAULT_DELAY);
      err_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      mar_q     <= mar_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      dly_q     <= dly_d;
      err_q     <= err_d;
    end
  end

  assign bus.mar_o       = mar_q;
  assign bus.data_o      = data_q;
  assign bus.ce_o        = out_vld_q & ctrl_q.ce;
  assign bus.rw_o        = out_vld_q & ctrl_q.rw;
  assign bus.clr_o       = out_vld_q & ctrl_q.clr;
  assign bus.out_valid_o = out_vld_q;
  assign bus.busy_o      = busy;
  assign bus.dly_o       = dly_q;
  assign bus.dly_err_o   = err_q;
endmodule

// File: tb/tb_mem_bus_delay_line.sv
// Directed bench for mem_bus_delay_line: delay, bubbles, stall, flush, delay loads, extremes, reset.
module tb_mem_bus_delay_line;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mem_bus_delay_line_if #(.ADDR_W(8), .DATA_W(32), .DLY_W(4)) bus ();

  mem_bus_delay_line #(
    .ADDR_W(8), .DATA_W(32), .MAX_DELAY(8), .DEFAULT_DELAY(4), .DLY_W(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 ns after the active falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid_i = 1'b0;
    bus.mar_i      = '0;
    bus.data_i     = '0;
    bus.ce_i       = 1'b0;
    bus.rw_i       = 1'b0;
    bus.clr_i      = 1'b0;
    bus.stall_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.dly_load_i = 1'b0;
    bus.dly_i      = '0;
  endtask

  task automatic send(input logic [7:0] m, input logic [31:0] d, input logic ce, input logic rw, input logic clr);
    bus.in_valid_i = 1'b1;
    bus.mar_i      = m;
    bus.data_i     = d;
    bus.ce_i       = ce;
    bus.rw_i       = rw;
    bus.clr_i      = clr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    tick();
    tick();
    checks++; if (bus.mar_o !== 8'h00) begin failures++; $display("FAIL reset_mar actual=%h required=00", bus.mar_o); end
    checks++; if (bus.data_o !== 32'h0) begin failures++; $display("FAIL reset_data actual=%h required=0", bus.data_o); end
    checks++; if ({bus.ce_o, bus.rw_o, bus.clr_o} !== 3'b000) begin failures++; $display("FAIL reset_ctrl actual=%b required=000", {bus.ce_o, bus.rw_o, bus.clr_o}); end
    checks++; if ({bus.out_valid_o, bus.busy_o, bus.dly_err_o} !== 3'b000) begin failures++; $display("FAIL reset_flags actual=%b required=000", {bus.out_valid_o, bus.busy_o, bus.dly_err_o}); end
    checks++; if (bus.dly_o !== 4'd4) begin failures++; $display("FAIL reset_dly actual=%0d required=4", bus.dly_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_delay();
    logic       ev, eb;
    logic [7:0] em;
    for (int n = 0; n < 14; n++) begin
      idle_in();
      if (n < 8) send(8'(8'h10 + n), 32'(32'h1000_0000 + n), 1'b1, (n % 2) == 1, 1'b0);
      tick();
      ev = (n >= 4) && (n <= 11);
      eb = (n <= 10);
      em = (n >= 4) ? 8'(8'h10 + ((n > 11) ? 7 : n - 4)) : 8'h00;
      checks++; if (bus.out_valid_o !== ev) begin failures++; $display("FAIL basic_valid e=%0d actual=%b required=%b", n, bus.out_valid_o, ev); end
      checks++; if (bus.busy_o !== eb) begin failures++; $display("FAIL basic_busy e=%0d actual=%b required=%b", n, bus.busy_o, eb); end
      checks++; if (bus.ce_o !== ev) begin failures++; $display("FAIL basic_ce e=%0d actual=%b required=%b", n, bus.ce_o, ev); end
      if (n >= 4) begin
        checks++; if (bus.mar_o !== em) begin failures++; $display("FAIL basic_mar e=%0d actual=%h required=%h", n, bus.mar_o, em); end
      end
      if (ev) begin
        checks++; if (bus.data_o !== 32'(32'h1000_0000 + n - 4)) begin failures++; $display("FAIL basic_data e=%0d actual=%h required=%h", n, bus.data_o, 32'(32'h1000_0000 + n - 4)); end
        checks++; if (bus.rw_o !== ((n - 4) % 2 == 1)) begin failures++; $display("FAIL basic_rw e=%0d actual=%b", n, bus.rw_o); end
      end
    end
  endtask

  task automatic test_bubbles();
    logic       ev;
    logic [7:0] em;
    for (int n = 0; n < 8; n++) begin
      idle_in();
      case (n)
        0: send(8'h01, 32'hA1, 1'b1, 1'b0, 1'b0);
        1: begin send(8'h02, 32'hA2, 1'b1, 1'b1, 1'b1); bus.in_valid_i = 1'b0; end
        2: send(8'h03, 32'hA3, 1'b1, 1'b0, 1'b0);
        default: ;
      endcase
      tick();
      if (n >= 4) begin
        ev = (n == 4) || (n == 6);
        em = (n <= 5) ? 8'h01 : 8'h03;
        checks++; if (bus.out_valid_o !== ev) begin failures++; $display("FAIL bubble_valid e=%0d actual=%b required=%b", n, bus.out_valid_o, ev); end
        checks++; if ({bus.ce_o, bus.rw_o, bus.clr_o} !== {ev, 2'b00}) begin failures++; $display("FAIL bubble_ctrl e=%0d actual=%b required=%b", n, {bus.ce_o, bus.rw_o, bus.clr_o}, {ev, 2'b00}); end
        checks++; if (bus.mar_o !== em) begin failures++; $display("FAIL bubble_mar e=%0d actual=%h required=%h", n, bus.mar_o, em); end
      end
    end
  endtask

  task automatic test_stall();
    logic       ev, eb;
    logic [7:0] em;
    for (int e = 0; e < 15; e++) begin
      idle_in();
      if (e <= 5) send(8'(8'h20 + e), 32'(e), 1'b1, 1'b0, 1'b0);
      if (e >= 6 && e <= 8) begin
        bus.stall_i = 1'b1;
        send(8'hEE, 32'hEEEE_EEEE, 1'b1, 1'b1, 1'b1);
      end
      if (e == 7) begin bus.dly_load_i = 1'b1; bus.dly_i = 4'd2; end
      tick();
      case (e)
        4:       begin ev = 1'b1; em = 8'h20; end
        5,6,7,8: begin ev = 1'b1; em = 8'h21; end
        9:       begin ev = 1'b1; em = 8'h22; end
        10:      begin ev = 1'b1; em = 8'h23; end
        11:      begin ev = 1'b1; em = 8'h24; end
        12:      begin ev = 1'b1; em = 8'h25; end
        default: begin ev = 1'b0; em = 8'h00; end
      endcase
      eb = (e <= 11);
      checks++; if (bus.out_valid_o !== ev) begin failures++; $display("FAIL stall_valid e=%0d actual=%b required=%b", e, bus.out_valid_o, ev); end
      checks++; if (bus.busy_o !== eb) begin failures++; $display("FAIL stall_busy e=%0d actual=%b required=%b", e, bus.busy_o, eb); end
      if (ev) begin
        checks++; if (bus.mar_o !== em) begin failures++; $display("FAIL stall_mar e=%0d actual=%h required=%h", e, bus.mar_o, em); end
      end
      if (e == 7) begin
        checks++; if ({bus.dly_err_o, bus.dly_o} !== {1'b0, 4'd4}) begin failures++; $display("FAIL stall_load err=%b dly=%0d required err=0 dly=4", bus.dly_err_o, bus.dly_o); end
      end
    end
  endtask

  task automatic test_flush();
    for (int e = 0; e < 11; e++) begin
      idle_in();
      if (e <= 2) send(8'(8'h30 + e), 32'(e), 1'b1, 1'b0, 1'b0);
      if (e == 3) begin bus.flush_i = 1'b1; send(8'hAA, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0); end
      tick();
      checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid e=%0d actual=%b required=0", e, bus.out_valid_o); end
      checks++; if (bus.busy_o !== (e <= 2)) begin failures++; $display("FAIL flush_busy e=%0d actual=%b required=%b", e, bus.busy_o, e <= 2); end
      checks++; if (bus.mar_o !== 8'h25) begin failures++; $display("FAIL flush_mar e=%0d actual=%h required=25", e, bus.mar_o); end
    end
  endtask

  task automatic test_delay_change();
    for (int e = 0; e < 14; e++) begin
      idle_in();
      case (e)
        0:  send(8'h40, 32'h40, 1'b1, 1'b0, 1'b0);
        1:  begin bus.dly_load_i = 1'b1; bus.dly_i = 4'd2; end
        6:  begin bus.dly_load_i = 1'b1; bus.dly_i = 4'd2; send(8'h41, 32'h41, 1'b1, 1'b0, 1'b0); end
        10: begin bus.dly_load_i = 1'b1; bus.dly_i = 4'd0; end
        11: begin bus.dly_load_i = 1'b1; bus.dly_i = 4'd15; end
        12: send(8'h42, 32'h42, 1'b1, 1'b0, 1'b0);
        13: begin bus.flush_i = 1'b1; bus.dly_load_i = 1'b1; bus.dly_i = 4'd1; end
        default: ;
      endcase
      tick();
      case (e)
        1: begin
          checks++; if ({bus.dly_err_o, bus.dly_o} !== {1'b1, 4'd4}) begin failures++; $display("FAIL dly_reject err=%b dly=%0d required err=1 dly=4", bus.dly_err_o, bus.dly_o); end
        end
        2: begin
          checks++; if (bus.dly_err_o !== 1'b0) begin failures++; $display("FAIL dly_err_pulse actual=%b required=0", bus.dly_err_o); end
        end
        4: begin
          checks++; if ({bus.out_valid_o, bus.mar_o} !== {1'b1, 8'h40}) begin failures++; $display("FAIL dly_drain v=%b mar=%h required v=1 mar=40", bus.out_valid_o, bus.mar_o); end
        end
        5, 9: begin
          checks++; if ({bus.out_valid_o, bus.busy_o} !== 2'b00) begin failures++; $display("FAIL dly_idle e=%0d v=%b busy=%b required 0 0", e, bus.out_valid_o, bus.busy_o); end
        end
        6: begin
          checks++; if ({bus.dly_err_o, bus.dly_o} !== {1'b0, 4'd2}) begin failures++; $display("FAIL dly_accept err=%b dly=%0d required err=0 dly=2", bus.dly_err_o, bus.dly_o); end
        end
        7: begin
          checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL dly2_early actual=%b required=0", bus.out_valid_o); end
        end
        8: begin
          checks++; if ({bus.out_valid_o, bus.mar_o} !== {1'b1, 8'h41}) begin failures++; $display("FAIL dly2_out v=%b mar=%h required v=1 mar=41", bus.out_valid_o, bus.mar_o); end
        end
        10: begin
          checks++; if (bus.dly_o !== 4'd1) begin failures++; $display("FAIL dly_clamp_lo actual=%0d required=1", bus.dly_o); end
        end
        11: begin
          checks++; if (bus.dly_o !== 4'd8) begin failures++; $display("FAIL dly_clamp_hi actual=%0d required=8", bus.dly_o); end
        end
        12: begin
          checks++; if ({bus.busy_o, bus.out_valid_o} !== 2'b10) begin failures++; $display("FAIL dly8_busy busy=%b v=%b required 1 0", bus.busy_o, bus.out_valid_o); end
        end
        13: begin
          checks++; if ({bus.dly_err_o, bus.dly_o, bus.busy_o, bus.out_valid_o} !== {1'b0, 4'd1, 2'b00}) begin failures++; $display("FAIL dly_flush_load err=%b dly=%0d busy=%b v=%b required 0 1 0 0", bus.dly_err_o, bus.dly_o, bus.busy_o, bus.out_valid_o); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_d1_stream();
    logic        ev;
    int          j;
    for (int n = 0; n < 22; n++) begin
      idle_in();
      if (n < 20) send(8'(8'h50 + n), 32'(n) * 32'h0101_0101, 1'b1, (n % 2) == 1, (n % 3) == 0);
      tick();
      ev = (n >= 1) && (n <= 20);
      j  = n - 1;
      checks++; if (bus.out_valid_o !== ev) begin failures++; $display("FAIL d1_valid e=%0d actual=%b required=%b", n, bus.out_valid_o, ev); end
      checks++; if (bus.busy_o !== (n <= 19)) begin failures++; $display("FAIL d1_busy e=%0d actual=%b required=%b", n, bus.busy_o, n <= 19); end
      if (ev) begin
        checks++; if (bus.mar_o !== 8'(8'h50 + j)) begin failures++; $display("FAIL d1_mar e=%0d actual=%h required=%h", n, bus.mar_o, 8'(8'h50 + j)); end
        checks++; if (bus.data_o !== 32'(j) * 32'h0101_0101) begin failures++; $display("FAIL d1_data e=%0d actual=%h required=%h", n, bus.data_o, 32'(j) * 32'h0101_0101); end
        checks++; if ({bus.ce_o, bus.rw_o, bus.clr_o} !== {1'b1, (j % 2) == 1, (j % 3) == 0}) begin failures++; $display("FAIL d1_ctrl e=%0d actual=%b", n, {bus.ce_o, bus.rw_o, bus.clr_o}); end
      end
    end
  endtask

  task automatic test_d8_stream();
    logic        ev;
    int          j;
    logic [31:0] ed;
    idle_in();
    bus.dly_load_i = 1'b1;
    bus.dly_i      = 4'd8;
    tick();
    checks++; if ({bus.dly_err_o, bus.dly_o} !== {1'b0, 4'd8}) begin failures++; $display("FAIL d8_load err=%b dly=%0d required err=0 dly=8", bus.dly_err_o, bus.dly_o); end
    for (int n = 0; n < 29; n++) begin
      idle_in();
      if (n < 20) send(8'(8'h60 + n), ((n % 2) == 1) ? 32'h0000_0000 : 32'hFFFF_FFFF, 1'b1, (n % 2) == 1, (n % 2) == 0);
      tick();
      ev = (n >= 8) && (n <= 27);
      j  = n - 8;
      ed = ((j % 2) == 1) ? 32'h0000_0000 : 32'hFFFF_FFFF;
      checks++; if (bus.out_valid_o !== ev) begin failures++; $display("FAIL d8_valid e=%0d actual=%b required=%b", n, bus.out_valid_o, ev); end
      checks++; if (bus.busy_o !== (n <= 26)) begin failures++; $display("FAIL d8_busy e=%0d actual=%b required=%b", n, bus.busy_o, n <= 26); end
      if (ev) begin
        checks++; if (bus.mar_o !== 8'(8'h60 + j)) begin failures++; $display("FAIL d8_mar e=%0d actual=%h required=%h", n, bus.mar_o, 8'(8'h60 + j)); end
        checks++; if (bus.data_o !== ed) begin failures++; $display("FAIL d8_data e=%0d actual=%h required=%h", n, bus.data_o, ed); end
        checks++; if ({bus.ce_o, bus.rw_o, bus.clr_o} !== {1'b1, (j % 2) == 1, (j % 2) == 0}) begin failures++; $display("FAIL d8_ctrl e=%0d actual=%b", n, {bus.ce_o, bus.rw_o, bus.clr_o}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < 5; e++) begin
      idle_in();
      send(8'(8'h70 + e), 32'(32'h7000 + e), 1'b1, 1'b1, 1'b0);
      tick();
    end
    idle_in();
    rst_n = 1'b0;
    tick();
    checks++; if ({bus.mar_o, bus.data_o} !== 40'h0) begin failures++; $display("FAIL rstmid_bus mar=%h data=%h required 0", bus.mar_o, bus.data_o); end
    checks++; if ({bus.ce_o, bus.rw_o, bus.clr_o, bus.out_valid_o, bus.busy_o, bus.dly_err_o} !== 6'b0) begin failures++; $display("FAIL rstmid_flags actual=%b required=000000", {bus.ce_o, bus.rw_o, bus.clr_o, bus.out_valid_o, bus.busy_o, bus.dly_err_o}); end
    checks++; if (bus.dly_o !== 4'd4) begin failures++; $display("FAIL rstmid_dly actual=%0d required=4", bus.dly_o); end
    rst_n = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++; if ({bus.out_valid_o, bus.mar_o} !== 9'h0) begin failures++; $display("FAIL rstmid_ghost e=%0d v=%b mar=%h required v=0 mar=00", e, bus.out_valid_o, bus.mar_o); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    test_reset();
    test_basic_delay();
    test_bubbles();
    test_stall();
    test_flush();
    test_delay_change();
    test_d1_stream();
    test_d8_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bus_delay_line.md
# mem_bus_delay_line

Parametrised, runtime-programmable delay line for the memory request bus (address, data, chip enable, read/write, clear). It sits between the pipeline's memory-request stage and the RAM model and emulates memory-path latency. It replaces the fixed-depth, fixed-width delay with per-entry valid tracking, a delay selectable at run time, stall and flush controls, and bubble-safe outputs.

## Interface
- ADDR_W, 8, address (MAR) width
- DATA_W, 32, data width
- MAX_DELAY, 8, maximum delay in cycles (≥1)
- DEFAULT_DELAY, 4, delay loaded at reset (1..MAX_DELAY)
- DLY_W, $clog2(MAX_DELAY+1), width of delay fields (derived)

Ports:
- clk  in  1  clock; all state updates on the falling edge
- rst_n  in  1  reset, synchronous, active-low
- mar_i  in  ADDR_W  request address
- data_i  in  DATA_W  request data
- ce_i / rw_i / clr_i  in  1 each  chip enable / read-write / clear
- in_valid_i  in  1  request present; 0 inserts a bubble
- stall_i  in  1  freeze the whole line
- flush_i  in  1  discard all in-flight requests
- dly_load_i  in  1  request a delay change
- dly_i  in  DLY_W  requested delay
- mar_o / data_o  out  ADDR_W / DATA_W  delayed address / data
- ce_o / rw_o / clr_o  out  1 each  delayed controls, gated by out_valid_o
- out_valid_o  out  1  outputs carry a real request
- busy_o  out  1  at least one valid entry is held internally
- dly_o  out  DLY_W  active delay
- dly_err_o  out  1  one-cycle pulse: a delay load was rejected

## Operation
- Reset (rst_n=0 at a falling edge): all entries invalid; all outputs 0, except dly_o=DEFAULT_DELAY; dly_err_o=0.
- Normal edge (no stall, no flush): the line advances one position. The input bundle is captured together with in_valid_i. The output registers load the bundle captured D edges earlier, where D=dly_o.
- Bubbles: when out_valid_o=0, ce_o, rw_o and clr_o are 0. mar_o and data_o hold their last valid value, so bubbles never strobe the memory.
- Priority at each edge: rst_n, then flush_i, then stall_i, then normal operation.
- Stall: nothing shifts, no input is captured, outputs and busy_o hold, and a dly_load_i is ignored with no error.
- Flush:
  - All entries and out_valid_o clear.
  - Input presented on the same edge is dropped.
  - ce_o, rw_o and clr_o go to 0; mar_o and data_o hold.
  - A dly_load_i on the same edge is accepted.
- Delay load:
  - Accepted only when busy_o=0 and out_valid_o=0, or together with a flush.
  - The accepted value is clamped: 0 becomes 1, values above MAX_DELAY become MAX_DELAY. dly_o updates at the same edge.
  - Otherwise the load is rejected: dly_err_o=1 for one cycle and dly_o is unchanged.
  - An input captured on the edge a load is accepted uses the new delay.
- busy_o is the OR of all internal entry valid bits. The output register is excluded.

## Timing
- Latency: a request sampled at edge k appears on the outputs after edge k+D, with D counted in non-stalled edges. Stalled edges add one cycle each.
- Throughput: one request per non-stalled edge, with no gaps required.
- D=1: the output follows the input by exactly one falling edge.
- D=MAX_DELAY: all MAX_DELAY storage positions are in use. There is no overflow condition, because capture and retire are lock-step.
- Reset mid-stream: in-flight requests are lost and the line is empty at the next edge.
- dly_err_o and flush effects are visible after the same falling edge on which they are sampled.

## Structure
- Package mem_bus_delay_pkg holds:
  - a packed typedef of the control triple {ce, rw, clr} and its width constant CTRL_W=3;
  - the clamp function for delay values;
  - default parameter constants.
- Sub-module mem_bus_delay_stage: one register stage holding payload plus valid, with stall-hold and flush-clear. The top instantiates MAX_DELAY of them and adds the output tap mux, the delay register and the load/error logic.
- The top-level implementation target is 150–300 lines of RTL.

## Test plan
- Reset and basic delay: hold rst_n=0 for 2 edges, then check all outputs are 0 and dly_o=4. Stream mar=0x10..0x17 with ce=1, valid=1. Each mar appears 4 edges later with ce_o=1 and out_valid_o=1; busy_o falls after the last request.
- Bubbles and stall: send valid, invalid, valid with mar 0x01, 0x02, 0x03. The output shows 0x01, then a bubble with ce_o=0 and mar_o still 0x01, then 0x03. Asserting stall_i for 3 edges mid-stream delays every later output by exactly 3 edges with no loss.
- Flush: with 3 requests in flight, assert flush_i together with a valid input mar=0xAA. out_valid_o=0 and busy_o=0 next edge, and 0xAA never appears.
- Delay change:
  - Load dly_i=2 while busy: dly_err_o pulses once and dly_o stays 4.
  - After draining, load 2: dly_o=2 and the next request emerges 2 edges later.
  - Loads of 0 and 15 clamp to 1 and 8 respectively.
- Extremes: with D=1, a back-to-back stream of 20 requests matches input shifted by 1 edge. With D=8, 20 requests match input shifted by 8 edges, and a full-width pattern (data 0xFFFFFFFF / 0x00000000 alternating) passes intact.
- Reset mid-operation: assert rst_n=0 with 5 requests in flight. On the next edge all outputs are 0, and none of the in-flight requests reappears.
